// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus arbiter: source IDs, the
// "no dependency" tag and the result-entry layout carried on the CDB.
package cdb_pkg;

  localparam int RoB_WIDTH = 8;

  // Tag value meaning "operand does not wait on any RoB entry".
  localparam logic [8:0] NON_DEP = 9'b100000000;

  // Producer identifiers, also driven on CDB_src.
  localparam logic SRC_RS  = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  // One buffered result, as broadcast on the CDB.
  typedef struct packed {
    logic [RoB_WIDTH-1:0] RoB_index;
    logic [31:0]          value;
  } result_entry_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// result_fifo: small per-producer result queue feeding the CDB arbiter.
// The head is read combinationally so an entry pushed at one edge can be
// popped into the CDB registers at the very next edge.
module result_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 40
) (
  input  logic          Sys_clk,
  input  logic          Sys_rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle does not open room for a push.
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr_reg];

  // Storage write; contents need no reset because the count guards them.
  always_ff @(posedge Sys_clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Flag a producer that pushed while full; that result is lost.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      assert (!(push && full))
        else $warning("result_fifo: push dropped while full");
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one CDB between the RS (ALU) and LSB result producers.
// Each producer owns a result_fifo; one head entry per enabled cycle is
// moved into the CDB output registers.
// Build option: CDB_ARB_FIXED_PRIO_EN -- when defined the LSB wins every
// tie; otherwise ties alternate round-robin on the last granted source.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int RoB_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Sys_clk,
  input  logic                 Sys_rst,
  input  logic                 Sys_rdy,
  input  logic                 RoBCA_flush,
  input  logic                 RSCA_en,
  input  logic [RoB_WIDTH-1:0] RSCA_RoB_index,
  input  logic [31:0]          RSCA_value,
  output logic                 CARS_full,
  input  logic                 LSBCA_en,
  input  logic [RoB_WIDTH-1:0] LSBCA_RoB_index,
  input  logic [31:0]          LSBCA_value,
  output logic                 CALSB_full,
  output logic                 CDB_en,
  output logic [RoB_WIDTH-1:0] CDB_RoB_index,
  output logic [31:0]          CDB_value,
  output logic                 CDB_src
);

  localparam int EW = RoB_WIDTH + 32;

  logic [1:0]    src_en;
  logic [EW-1:0] din_vec  [2];
  logic [EW-1:0] head_vec [2];
  logic [1:0]    push_vec;
  logic [1:0]    pop_vec;
  logic [1:0]    full_vec;
  logic [1:0]    empty_vec;
  logic          pop_any;
  logic          grant_lsb;
  logic [EW-1:0] grant_entry;

  assign src_en[SRC_RS]   = RSCA_en;
  assign src_en[SRC_LSB]  = LSBCA_en;
  assign din_vec[SRC_RS]  = {RSCA_RoB_index, RSCA_value};
  assign din_vec[SRC_LSB] = {LSBCA_RoB_index, LSBCA_value};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // Pushes only land while the pipeline is enabled and not flushing.
      assign push_vec[gi] = src_en[gi] & Sys_rdy & ~RoBCA_flush;

      result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (EW)
      ) u_fifo (
        .Sys_clk (Sys_clk),
        .Sys_rst (Sys_rst),
        .flush   (RoBCA_flush),
        .push    (push_vec[gi]),
        .din     (din_vec[gi]),
        .pop     (pop_vec[gi]),
        .head    (head_vec[gi]),
        .full    (full_vec[gi]),
        .empty   (empty_vec[gi])
      );
    end
  endgenerate

  assign CARS_full  = full_vec[SRC_RS];
  assign CALSB_full = full_vec[SRC_LSB];

`ifdef CDB_ARB_FIXED_PRIO_EN
  // Loads are latency-critical: the LSB wins whenever it has a result.
  assign grant_lsb = ~empty_vec[SRC_LSB];
`else
  logic last_grant_reg;

  // LSB wins if it is the only source, or on a tie when RS went last.
  assign grant_lsb = ~empty_vec[SRC_LSB] &
                     (empty_vec[SRC_RS] | (last_grant_reg == SRC_RS));

  // Remember the winner of each pop; reset/flush favour RS on the next tie.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      last_grant_reg <= SRC_LSB;
    end else if (RoBCA_flush) begin
      last_grant_reg <= SRC_LSB;
    end else if (pop_any) begin
      last_grant_reg <= grant_lsb;
    end
  end
`endif

  assign pop_any          = Sys_rdy & ~RoBCA_flush & ~(&empty_vec);
  assign pop_vec[SRC_RS]  = pop_any & ~grant_lsb;
  assign pop_vec[SRC_LSB] = pop_any & grant_lsb;
  assign grant_entry      = grant_lsb ? head_vec[SRC_LSB] : head_vec[SRC_RS];

  // CDB broadcast registers; payload holds its last value when idle.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      CDB_en        <= 1'b0;
      CDB_RoB_index <= '0;
      CDB_value     <= '0;
      CDB_src       <= SRC_RS;
    end else if (RoBCA_flush) begin
      CDB_en <= 1'b0;
    end else if (Sys_rdy) begin
      CDB_en <= pop_any;
      if (pop_any) begin
        CDB_RoB_index <= grant_entry[EW-1:32];
        CDB_value     <= grant_entry[31:0];
        CDB_src       <= grant_lsb;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a vector table for single-cycle
// behaviour plus directed sequences (overflow, flush, freeze, reset) whose
// broadcasts are checked against an expected-result queue.
module tb_cdb_arbiter;

  logic        Sys_clk;
  logic        Sys_rst;
  logic        Sys_rdy;
  logic        RoBCA_flush;
  logic        RSCA_en;
  logic [7:0]  RSCA_RoB_index;
  logic [31:0] RSCA_value;
  logic        CARS_full;
  logic        LSBCA_en;
  logic [7:0]  LSBCA_RoB_index;
  logic [31:0] LSBCA_value;
  logic        CALSB_full;
  logic        CDB_en;
  logic [7:0]  CDB_RoB_index;
  logic [31:0] CDB_value;
  logic        CDB_src;

  int n_vec = 0;
  int n_err = 0;

  logic [40:0] sb [$];

  cdb_arbiter #(.RoB_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .Sys_clk         (Sys_clk),
    .Sys_rst         (Sys_rst),
    .Sys_rdy         (Sys_rdy),
    .RoBCA_flush     (RoBCA_flush),
    .RSCA_en         (RSCA_en),
    .RSCA_RoB_index  (RSCA_RoB_index),
    .RSCA_value      (RSCA_value),
    .CARS_full       (CARS_full),
    .LSBCA_en        (LSBCA_en),
    .LSBCA_RoB_index (LSBCA_RoB_index),
    .LSBCA_value     (LSBCA_value),
    .CALSB_full      (CALSB_full),
    .CDB_en          (CDB_en),
    .CDB_RoB_index   (CDB_RoB_index),
    .CDB_value       (CDB_value),
    .CDB_src         (CDB_src)
  );

  initial Sys_clk = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  typedef struct {
    logic        rs_en;
    logic [7:0]  rs_idx;
    logic [31:0] rs_val;
    logic        lsb_en;
    logic [7:0]  lsb_idx;
    logic [31:0] lsb_val;
    logic        rdy;
    logic        e_en;
    logic [7:0]  e_idx;
    logic [31:0] e_val;
    logic        e_src;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic re, input logic [7:0] ri, input logic [31:0] rv,
                       input logic le, input logic [7:0] li, input logic [31:0] lv,
                       input logic rdy, input logic fl);
    RSCA_en = re; RSCA_RoB_index = ri; RSCA_value = rv;
    LSBCA_en = le; LSBCA_RoB_index = li; LSBCA_value = lv;
    Sys_rdy = rdy; RoBCA_flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
  endtask

  // Advance one clock and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    Sys_rst = 1'b1;
    tick();
    tick();
    Sys_rst = 1'b0;
  endtask

  task automatic chk_cdb(input string name, input logic en, input logic [7:0] idx,
                         input logic [31:0] val, input logic src);
    chk({name, "_en"},  64'(CDB_en), 64'(en));
    chk({name, "_idx"}, 64'(CDB_RoB_index), 64'(idx));
    chk({name, "_val"}, 64'(CDB_value), 64'(val));
    chk({name, "_src"}, 64'(CDB_src), 64'(src));
  endtask

  // Overflow-sequence entry codes: <100 RS entry n, >=100 LSB entry n-100.
  function automatic logic [40:0] mk(input int code);
    if (code >= 100) mk = {1'b1, 8'(20 + code - 100), 32'h200 + 32'(code - 100)};
    else             mk = {1'b0, 8'(10 + code), 32'h100 + 32'(code)};
  endfunction

  task automatic sb_check();
    logic [40:0] exp_e;
    if (CDB_en) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: got idx %0d, want no broadcast", CDB_RoB_index);
      end else begin
        exp_e = sb.pop_front();
        $display("cdb: src %0d idx %0d val %0h", CDB_src, CDB_RoB_index, CDB_value);
        chk("sb_entry", 64'({CDB_src, CDB_RoB_index, CDB_value}), 64'(exp_e));
      end
    end
  endtask

  initial begin
    int ord [$];
    logic [7:0] full_exp;

    // ---------------- vector table ----------------
    tbl[0]  = '{1'b1, 8'd1, 32'hA,  1'b1, 8'd2, 32'hB,  1'b1, 1'b0, 8'd0, 32'h0,    1'b0};
    tbl[1]  = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b1, 8'd1, 32'hA,    1'b0};
    tbl[2]  = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b1, 8'd2, 32'hB,    1'b1};
    tbl[3]  = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b0, 8'd2, 32'hB,    1'b1};
    tbl[4]  = '{1'b1, 8'd5, 32'h1234, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd2, 32'hB,   1'b1};
    tbl[5]  = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b1, 8'd5, 32'h1234, 1'b0};
    tbl[6]  = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b0, 8'd5, 32'h1234, 1'b0};
    tbl[7]  = '{1'b1, 8'd3, 32'h33, 1'b1, 8'd4, 32'h44, 1'b1, 1'b0, 8'd5, 32'h1234, 1'b0};
    tbl[8]  = '{1'b1, 8'd6, 32'h66, 1'b1, 8'd8, 32'h88, 1'b1, 1'b1, 8'd4, 32'h44,   1'b1};
    tbl[9]  = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b1, 8'd3, 32'h33,   1'b0};
    tbl[10] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b1, 8'd8, 32'h88,   1'b1};
    tbl[11] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b1, 8'd6, 32'h66,   1'b0};
    tbl[12] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b0, 8'd6, 32'h66,   1'b0};
    tbl[13] = '{1'b1, 8'd9, 32'h99, 1'b0, 8'd0, 32'h0,  1'b0, 1'b0, 8'd6, 32'h66,   1'b0};
    tbl[14] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,  1'b1, 1'b0, 8'd6, 32'h66,   1'b0};
`ifdef CDB_ARB_FIXED_PRIO_EN
    tbl[1].e_idx = 8'd2; tbl[1].e_val = 32'hB;  tbl[1].e_src = 1'b1;
    tbl[2].e_idx = 8'd1; tbl[2].e_val = 32'hA;  tbl[2].e_src = 1'b0;
    tbl[3].e_idx = 8'd1; tbl[3].e_val = 32'hA;  tbl[3].e_src = 1'b0;
    tbl[4].e_idx = 8'd1; tbl[4].e_val = 32'hA;  tbl[4].e_src = 1'b0;
    tbl[9].e_idx = 8'd8; tbl[9].e_val = 32'h88; tbl[9].e_src = 1'b1;
    tbl[10].e_idx = 8'd3; tbl[10].e_val = 32'h33; tbl[10].e_src = 1'b0;
`endif

    // ---------------- reset state ----------------
    Sys_rst = 1'b0;
    idle();
    #1 Sys_rst = 1'b1;
    #2;
    chk_cdb("reset", 1'b0, 8'd0, 32'd0, 1'b0);
    chk("reset_cars_full", 64'(CARS_full), 64'(0));
    chk("reset_calsb_full", 64'(CALSB_full), 64'(0));
    tick();
    tick();
    Sys_rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rs_en, tbl[i].rs_idx, tbl[i].rs_val,
            tbl[i].lsb_en, tbl[i].lsb_idx, tbl[i].lsb_val, tbl[i].rdy, 1'b0);
      tick();
      $display("vec %0d: en %0d idx %0d val %0h src %0d", i, CDB_en, CDB_RoB_index, CDB_value, CDB_src);
      chk_cdb($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_idx, tbl[i].e_val, tbl[i].e_src);
    end

    // ---------------- RS overflow with LSB busy ----------------
    do_reset();
    sb.delete();
`ifdef CDB_ARB_FIXED_PRIO_EN
    ord = '{100, 101, 102, 103, 104, 0, 1, 2, 3, 7};
    full_exp = 8'b0011_1000;
`else
    ord = '{0, 100, 1, 101, 2, 102, 3, 103, 4, 104, 5, 6};
    full_exp = 8'b0100_0000;
`endif
    foreach (ord[k]) sb.push_back(mk(ord[k]));
    for (int e = 0; e < 8; e++) begin
      drive(1'b1, 8'(10 + e), 32'h100 + 32'(e),
            (e <= 4), 8'(20 + e), 32'h200 + 32'(e), 1'b1, 1'b0);
      tick();
      sb_check();
      chk($sformatf("ovf_cars_full_e%0d", e), 64'(CARS_full), 64'(full_exp[e]));
    end
    idle();
    for (int d = 0; d < 8; d++) begin
      tick();
      sb_check();
    end
    chk("ovf_all_drained", 64'(sb.size()), 64'(0));
    chk("ovf_calsb_full", 64'(CALSB_full), 64'(0));

    // ---------------- flush with Sys_rdy low ----------------
    for (int e = 0; e < 3; e++) begin
      drive(1'b1, 8'(30 + e), 32'h300 + 32'(e), 1'b1, 8'(40 + e), 32'h400 + 32'(e), 1'b1, 1'b0);
      tick();
    end
    chk("preflush_en", 64'(CDB_en), 64'(1));
    drive(1'b1, 8'd33, 32'h333, 1'b0, 8'd0, 32'd0, 1'b0, 1'b1);
    tick();
    chk("flush_en", 64'(CDB_en), 64'(0));
    idle();
    for (int d = 0; d < 4; d++) begin
      tick();
      chk($sformatf("postflush_en%0d", d), 64'(CDB_en), 64'(0));
    end
    // First tie after a flush
    drive(1'b1, 8'd34, 32'h340, 1'b1, 8'd44, 32'h440, 1'b1, 1'b0);
    tick();
    idle();
    tick();
`ifdef CDB_ARB_FIXED_PRIO_EN
    chk_cdb("flush_tie1", 1'b1, 8'd44, 32'h440, 1'b1);
    tick();
    chk_cdb("flush_tie2", 1'b1, 8'd34, 32'h340, 1'b0);
`else
    chk_cdb("flush_tie1", 1'b1, 8'd34, 32'h340, 1'b0);
    tick();
    chk_cdb("flush_tie2", 1'b1, 8'd44, 32'h440, 1'b1);
`endif
    // Flush with Sys_rdy high discards a same-cycle push
    drive(1'b1, 8'd35, 32'h350, 1'b0, 8'd0, 32'd0, 1'b1, 1'b1);
    tick();
    chk("flush_push_en0", 64'(CDB_en), 64'(0));
    idle();
    tick();
    chk("flush_push_en1", 64'(CDB_en), 64'(0));

    // ---------------- Sys_rdy freeze ----------------
    drive(1'b1, 8'd7, 32'h77, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'd12, 32'hC, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
    tick();
    chk_cdb("frz_start", 1'b1, 8'd7, 32'h77, 1'b0);
    for (int d = 0; d < 3; d++) begin
      drive(1'b1, 8'd13, 32'hD, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0);
      tick();
      chk_cdb($sformatf("frz%0d", d), 1'b1, 8'd7, 32'h77, 1'b0);
    end
    idle();
    tick();
    chk_cdb("frz_resume", 1'b1, 8'd12, 32'hC, 1'b0);
    tick();
    chk("frz_done_en", 64'(CDB_en), 64'(0));

    // ---------------- asynchronous reset mid-operation ----------------
    drive(1'b1, 8'd60, 32'h600, 1'b1, 8'd61, 32'h610, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'd62, 32'h620, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
    tick();
    idle();
    chk("prerst_en", 64'(CDB_en), 64'(1));
    #2 Sys_rst = 1'b1;
    #1;
    chk_cdb("async_rst", 1'b0, 8'd0, 32'd0, 1'b0);
    chk("async_rst_cars_full", 64'(CARS_full), 64'(0));
    tick();
    Sys_rst = 1'b0;
    tick();
    chk("postrst_en", 64'(CDB_en), 64'(0));
    drive(1'b1, 8'd70, 32'h700, 1'b1, 8'd71, 32'h710, 1'b1, 1'b0);
    tick();
    idle();
    tick();
`ifdef CDB_ARB_FIXED_PRIO_EN
    chk_cdb("rst_tie", 1'b1, 8'd71, 32'h710, 1'b1);
`else
    chk_cdb("rst_tie", 1'b1, 8'd70, 32'h700, 1'b0);
`endif
    tick();
    tick();
    chk("rst_tie_done_en", 64'(CDB_en), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters: RoB_WIDTH, default 8, RoB index width; FIFO_DEPTH, default 4, per-source result FIFO depth, power of two, at least 2.
REQ-002 Sys_clk  in  1  sole clock; all state on posedge.
REQ-003 Sys_rst  in  1  reset, asynchronous, active-high.
REQ-004 Sys_rdy  in  1  global enable; low = freeze all state.
REQ-005 RoBCA_flush  in  1  mispredict flush from RoB.
REQ-006 RSCA_en / RSCA_RoB_index / RSCA_value  in  1 / RoB_WIDTH / 32  ALU result from RS.
REQ-007 CARS_full  out  1  RS FIFO full; RS must not assert RSCA_en.
REQ-008 LSBCA_en / LSBCA_RoB_index / LSBCA_value  in  1 / RoB_WIDTH / 32  load/store result from LSB.
REQ-009 CALSB_full  out  1  LSB FIFO full.
REQ-010 CDB_en / CDB_RoB_index / CDB_value / CDB_src  out  1 / RoB_WIDTH / 32 / 1  single shared CDB broadcast; CDB_src 0=RS, 1=LSB.

Function
REQ-011 The block SHALL share one CDB between two result producers (RS, LSB), with one FIFO per producer.
REQ-012 Push: xxCA_en=1, FIFO not full, Sys_rdy=1, no flush -> entry {index,value} stored at the posedge.
REQ-013 xxCA_en while the FIFO is full SHALL drop the input and leave the FIFO unchanged; the simulation assertion fires.
REQ-014 CARS_full / CALSB_full SHALL be combinational from registered count (count==FIFO_DEPTH) only; a same-cycle pop does not clear them.
REQ-015 Each posedge with Sys_rdy=1, at least one FIFO non-empty, and no flush SHALL pop exactly one head entry into the CDB_* registers with CDB_en=1.
REQ-016 When no FIFO is non-empty, CDB_en SHALL be 0 at the next posedge; the other CDB_* outputs hold their values.
REQ-017 Grant: only one source non-empty -> grant it; both non-empty -> round-robin, the source not granted last wins; last_grant updates only on a pop.
REQ-018 Latency: a push at posedge k SHALL be broadcast no earlier than posedge k+1; with the FIFO empty and no contention, exactly k+1.
REQ-019 Simultaneous push and pop on one FIFO SHALL both occur; the count is unchanged.
REQ-020 Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
REQ-021 Sys_rdy=0 SHALL freeze FIFOs, last_grant and all CDB_* outputs, including CDB_en.
REQ-022 RoBCA_flush=1 at a posedge SHALL, regardless of Sys_rdy, empty both FIFOs, set CDB_en=0, set last_grant=LSB, and ignore same-cycle pushes.

Reset
REQ-023 Sys_rst high SHALL immediately force: FIFOs empty, CARS_full=CALSB_full=0, CDB_en=0, CDB_RoB_index=0, CDB_value=0, CDB_src=0, last_grant=LSB.
REQ-024 Reset asserted mid-operation SHALL discard all buffered results; the first grant after release goes to RS on a tie.

Configuration
REQ-025 Macro CDB_ARB_FIXED_PRIO_EN: when defined, the LSB SHALL always win ties (loads are latency-critical) and last_grant is unused; when undefined, round-robin per REQ-017.

Structure
REQ-026 Shared package cdb_pkg: RoB_WIDTH, NON_DEP (9'b100000000), source-ID constants SRC_RS=0 and SRC_LSB=1, and a result-entry struct typedef {RoB_index, value}.
REQ-027 One sub-module, result_fifo (parameterised depth; push/pop/full/empty/head), instantiated twice; the grant logic and CDB registers live in cdb_arbiter.

Verification
REQ-028 RS pushes {idx 5, 0x1234} into idle block -> next posedge CDB_en=1, idx 5, value 0x1234, src 0; following posedge CDB_en=0.
REQ-029 RS {1,0xA} and LSB {2,0xB} pushed same cycle, round-robin -> broadcast RS idx 1, then LSB idx 2 on consecutive cycles; with CDB_ARB_FIXED_PRIO_EN, LSB first.
REQ-030 5 RS pushes back-to-back, depth 4, LSB also busy -> CARS_full=1 after 4 stored; the 5th is dropped and the assertion fires; the 4 entries drain in order.
REQ-031 Both FIFOs hold 2 entries, RoBCA_flush pulsed with Sys_rdy=0 -> next posedge both empty, CDB_en=0, no stale broadcast afterward.
REQ-032 Sys_rdy low 3 cycles while CDB_en=1 idx 7 -> outputs frozen at idx 7; the pop resumes on the first posedge with Sys_rdy high.
REQ-033 Sys_rst asserted between edges with 3 entries queued -> outputs zero immediately, CARS_full=0; after release an RS/LSB tie grants RS.
